vend_ctrl: RTL and testbench

Sequencing controller for the coin-operated cola dispenser. Accepts 0.5-unit and 1.0-unit coin pulses, accumulates credit, and runs the dispense handshake with the mechanism once credit reaches the price. Returns change in 0.5-unit pulses. Sits between the coin-acceptor front end and the dispense/change actuators and supersedes the simple three-coin counter as the top-level vending sequencer.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_coin_sum.sv | 38 +++
 rtl/vend_ctrl.sv | 155 +++++++++++++++
 tb/tb_vend_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// ============================================================================
//  Module   : vend_pkg
//  Purpose  : Shared state encodings and coin constants for the vending sequencer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    typedef logic [4:0] state_t;

    localparam state_t ST_IDLE     = 5'b00001;
    localparam state_t ST_COLLECT  = 5'b00010;
    localparam state_t ST_DISPENSE = 5'b00100;
    localparam state_t ST_CHANGE   = 5'b01000;
    localparam state_t ST_REFUND   = 5'b10000;

    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] ONE  = 2'd2;

    function automatic logic is_busy(input state_t s);
        return |(s & (ST_DISPENSE | ST_CHANGE | ST_REFUND));
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_coin_sum.sv
// ============================================================================
//  Module   : vend_coin_sum
//  Purpose  : Coin pulse to 0.5-unit value conversion and registered reject pulse
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_coin_sum
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_half,
    input  logic       i_one,
    input  logic       i_busy,
    output logic [1:0] o_value,
    output logic       o_reject
);

    logic w_reject_d;
    logic r_reject_q;

    assign o_value    = (i_half ? HALF : 2'd0) | (i_one ? ONE : 2'd0);
    assign w_reject_d = i_busy & (i_half | i_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject_q <= 1'b0;
        end else begin
            r_reject_q <= w_reject_d;
        end
    end

    assign o_reject = r_reject_q;

endmodule

`default_nettype wire

// File: rtl/vend_ctrl.sv
// ============================================================================
//  Module   : vend_ctrl
//  Purpose  : Coin credit, dispense handshake and change sequencer.
//             Optional cancel input enabled by VEND_CANCEL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE   = 5,
    parameter int CNT_W   = 4,
    parameter int ACK_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_half,
    input  logic             pi_one,
`ifdef VEND_CANCEL_EN
    input  logic             pi_cancel,
`endif
    input  logic             dispense_ack,
    output logic             po_cola,
    output logic             po_change,
    output logic             po_reject,
    output logic             po_fault,
    output logic [CNT_W-1:0] credit,
    output logic             busy
);

    localparam int               TMO_W   = $clog2(ACK_TMO + 1);
    localparam logic [CNT_W-1:0] PRICE_C = CNT_W'(PRICE);
    localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(ACK_TMO);

    state_t           r_state_q,  w_state_d;
    logic [CNT_W-1:0] r_credit_q, w_credit_d;
    logic [TMO_W-1:0] r_tmo_q,    w_tmo_d;
    logic             r_cola_q,   w_cola_d;
    logic             r_change_q, w_change_d;
    logic             r_busy_q,   w_busy_d;
    logic             r_fault_q,  w_fault_d;

    logic [1:0]       w_value;
    logic [CNT_W-1:0] w_sum;
    logic [TMO_W-1:0] w_tmo_next;
    logic             w_cancel;

`ifdef VEND_CANCEL_EN
    assign w_cancel = pi_cancel;
`else
    assign w_cancel = 1'b0;
`endif

    vend_coin_sum u_coin_sum (
        .clk      (clk),
        .rst      (rst),
        .i_half   (pi_half),
        .i_one    (pi_one),
        .i_busy   (r_busy_q),
        .o_value  (w_value),
        .o_reject (po_reject)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_credit_d = r_credit_q;
        w_tmo_d    = r_tmo_q;
        w_change_d = 1'b0;
        w_fault_d  = r_fault_q;
        w_sum      = r_credit_q + CNT_W'(w_value);
        w_tmo_next = r_tmo_q + TMO_W'(1);

        case (r_state_q)
            ST_IDLE: begin
                if (w_value != 2'd0) begin
                    w_credit_d = w_sum;
                    w_state_d  = (w_sum >= PRICE_C) ? ST_DISPENSE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_credit_d = w_sum;
                if (w_cancel) begin
                    w_state_d = ST_REFUND;
                end else if (w_sum >= PRICE_C) begin
                    w_state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (dispense_ack) begin
                    w_credit_d = r_credit_q - PRICE_C;
                    w_state_d  = (r_credit_q != PRICE_C) ? ST_CHANGE : ST_IDLE;
                    w_tmo_d    = '0;
                end else if (w_tmo_next == TMO_C) begin
                    w_fault_d  = 1'b1;
                    w_state_d  = ST_REFUND;
                    w_tmo_d    = '0;
                end else begin
                    w_tmo_d    = w_tmo_next;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                // The registered pulse doubles as the high/low phase of the payout.
                if (!r_change_q) begin
                    w_change_d = 1'b1;
                    w_credit_d = r_credit_q - CNT_W'(1);
                end else if (r_credit_q == '0) begin
                    w_state_d  = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_cola_d = (w_state_d == ST_DISPENSE);
        w_busy_d = is_busy(w_state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_credit_q <= '0;
            r_tmo_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_credit_q <= w_credit_d;
            r_tmo_q    <= w_tmo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cola_q   <= 1'b0;
            r_change_q <= 1'b0;
            r_busy_q   <= 1'b0;
            r_fault_q  <= 1'b0;
        end else begin
            r_cola_q   <= w_cola_d;
            r_change_q <= w_change_d;
            r_busy_q   <= w_busy_d;
            r_fault_q  <= w_fault_d;
        end
    end

    assign po_cola   = r_cola_q;
    assign po_change = r_change_q;
    assign po_fault  = r_fault_q;
    assign credit    = r_credit_q;
    assign busy      = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
// ============================================================================
//  Module   : tb_vend_ctrl
//  Purpose  : Directed self-checking bench for vend_ctrl (PRICE=5, ACK_TMO=15)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_ctrl;

    logic       clk;
    logic       rst;
    logic       pi_half;
    logic       pi_one;
    logic       pi_cancel;
    logic       dispense_ack;
    logic       po_cola;
    logic       po_change;
    logic       po_reject;
    logic       po_fault;
    logic [3:0] credit;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int pulses;

    vend_ctrl #(
        .PRICE   (5),
        .CNT_W   (4),
        .ACK_TMO (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pi_half      (pi_half),
        .pi_one       (pi_one),
`ifdef VEND_CANCEL_EN
        .pi_cancel    (pi_cancel),
`endif
        .dispense_ack (dispense_ack),
        .po_cola      (po_cola),
        .po_change    (po_change),
        .po_reject    (po_reject),
        .po_fault     (po_fault),
        .credit       (credit),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; pi_half = 1'b0; pi_one = 1'b0; pi_cancel = 1'b0; dispense_ack = 1'b0;
        step(); step();
        chk("rst_credit", credit, 0);
        chk("rst_cola", po_cola, 0);
        chk("rst_change", po_change, 0);
        chk("rst_reject", po_reject, 0);
        chk("rst_fault", po_fault, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Five half-unit coins reach PRICE exactly
        for (int i = 1; i <= 5; i++) begin
            pi_half = 1'b1; step(); pi_half = 1'b0;
            chk("half_credit", credit, i);
            chk("half_cola", po_cola, (i == 5) ? 1 : 0);
        end
        chk("t1_busy", busy, 1);
        dispense_ack = 1'b1; step(); dispense_ack = 1'b0;
        chk("t1_ack_cola", po_cola, 0);
        chk("t1_ack_credit", credit, 0);
        chk("t1_ack_busy", busy, 0);
        step();
        chk("t1_no_change", po_change, 0);

        // 2 + 2 + 3 = 7, two units of change, with a reject during CHANGE
        pi_one = 1'b1; step(); pi_one = 1'b0;
        chk("t2_credit_a", credit, 2);
        pi_one = 1'b1; step(); pi_one = 1'b0;
        chk("t2_credit_b", credit, 4);
        pi_one = 1'b1; pi_half = 1'b1; step(); pi_one = 1'b0; pi_half = 1'b0;
        chk("t2_credit_c", credit, 7);
        chk("t2_cola", po_cola, 1);
        dispense_ack = 1'b1; step(); dispense_ack = 1'b0;
        chk("t2_ack_cola", po_cola, 0);
        chk("t2_ack_credit", credit, 2);
        chk("t2_ack_change", po_change, 0);
        chk("t2_ack_busy", busy, 1);
        step();
        chk("t2_p1_change", po_change, 1);
        chk("t2_p1_credit", credit, 1);
        pi_one = 1'b1; step(); pi_one = 1'b0;
        chk("t2_l1_change", po_change, 0);
        chk("t2_l1_reject", po_reject, 1);
        chk("t2_l1_credit", credit, 1);
        step();
        chk("t2_p2_change", po_change, 1);
        chk("t2_p2_credit", credit, 0);
        chk("t2_p2_reject", po_reject, 0);
        step();
        chk("t2_l2_change", po_change, 0);
        chk("t2_l2_busy", busy, 0);

        // Ack on the same cycle the timeout would fire: normal completion
        for (int i = 0; i < 3; i++) begin
            pi_one = 1'b1; step(); pi_one = 1'b0;
        end
        chk("t3_credit", credit, 6);
        chk("t3_cola", po_cola, 1);
        for (int i = 0; i < 14; i++) step();
        chk("t3_cola_held", po_cola, 1);
        dispense_ack = 1'b1; step(); dispense_ack = 1'b0;
        chk("t3_fault", po_fault, 0);
        chk("t3_cola_low", po_cola, 0);
        chk("t3_credit_rem", credit, 1);
        step();
        chk("t3_change", po_change, 1);
        step();
        chk("t3_busy", busy, 0);

        // No ack: timeout, fault, full refund of five units
        pi_one = 1'b1; step();
        step();
        pi_one = 1'b0; pi_half = 1'b1; step(); pi_half = 1'b0;
        chk("t4_credit", credit, 5);
        chk("t4_cola", po_cola, 1);
        for (int i = 0; i < 14; i++) step();
        chk("t4_cola_14", po_cola, 1);
        chk("t4_fault_14", po_fault, 0);
        step();
        chk("t4_fault", po_fault, 1);
        chk("t4_cola_low", po_cola, 0);
        chk("t4_refund_credit", credit, 5);
        chk("t4_busy", busy, 1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (po_change) pulses++;
        end
        chk("t4_busy_9", busy, 1);
        step();
        if (po_change) pulses++;
        chk("t4_pulses", pulses, 5);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_credit", credit, 0);
        chk("t4_fault_sticky", po_fault, 1);

        // Asynchronous reset in the middle of a dispense
        for (int i = 0; i < 3; i++) begin
            pi_one = 1'b1; step(); pi_one = 1'b0;
        end
        chk("t5_cola", po_cola, 1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_cola", po_cola, 0);
        chk("t5_rst_credit", credit, 0);
        chk("t5_rst_fault", po_fault, 0);
        chk("t5_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        pi_half = 1'b1; step(); pi_half = 1'b0;
        chk("t5_after_credit", credit, 1);
        pi_one = 1'b1; step(); pi_one = 1'b0;
        chk("t5_after_credit3", credit, 3);

`ifdef VEND_CANCEL_EN
        pi_cancel = 1'b1; step(); pi_cancel = 1'b0;
        chk("t6_busy", busy, 1);
        chk("t6_credit", credit, 3);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (po_change) pulses++;
        end
        chk("t6_pulses", pulses, 3);
        chk("t6_idle_busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
